disp_scan_ctrl: RTL and testbench

- Display controller for the CPU's 3-digit 7-segment readout.
- Converts an 8-bit binary value (0..255) to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto one shared external BCD-to-7-segment decoder, driving a one-hot digit-enable bus, with optional leading-zero blanking.

---
 rtl/disp_scan_ctrl_if.sv | 11 +
 rtl/disp_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_disp_scan_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - value/load request and digit-scan output bundle
interface disp_scan_ctrl_if;
  logic [7:0] VAL;
  logic       LOAD;
  logic       BUSY;
  logic [3:0] BCD;
  logic [2:0] DIG_EN;

  modport master (output VAL, output LOAD, input BUSY, input BCD, input DIG_EN);
  modport slave  (input VAL, input LOAD, output BUSY, output BCD, output DIG_EN);
endinterface

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - binary-to-BCD converter with multiplexed 3-digit scan
module disp_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DIV_W    = 16,
  parameter bit          LZB      = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  disp_scan_ctrl_if.slave bus
);
  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [11:0]      acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [3:0]       d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;

  logic [11:0]      acc_adj;
  logic [19:0]      shifted;
  logic             wrap;
  logic [3:0]       bcd;
  logic [2:0]       dig_en;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    d2_d    = d2_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    acc_adj = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
    shifted = {acc_adj, shift_q} << 1;
    case (state_q)
      IDLE: begin
        if (bus.LOAD || pend_q) begin
          shift_d = bus.VAL;
          acc_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (bus.LOAD) pend_d = 1'b1;
        shift_d = shifted[7:0];
        acc_d   = shifted[19:8];
        cnt_d   = cnt_q + 4'd1;
        // Eighth shift: the post-shift accumulator is the final result.
        if (cnt_q == 4'd7) begin
          d2_d    = shifted[19:16];
          d1_d    = shifted[15:12];
          d0_d    = shifted[11:8];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrap  = (pre_q >= DIV_LAST);
    pre_d = wrap ? '0 : pre_q + DIV_ONE;
    idx_d = idx_q;
    // Index values 2 and the illegal 3 both return to 0.
    if (wrap) idx_d = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
  end

  always_comb begin
    bcd    = 4'd0;
    dig_en = 3'b000;
    case (idx_q)
      2'd0: begin bcd = d0_q; dig_en = 3'b001; end
      2'd1: begin bcd = d1_q; dig_en = (LZB && d2_q == 4'd0 && d1_q == 4'd0) ? 3'b000 : 3'b010; end
      2'd2: begin bcd = d2_q; dig_en = (LZB && d2_q == 4'd0) ? 3'b000 : 3'b100; end
      default: begin bcd = 4'd0; dig_en = 3'b000; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      d2_q    <= '0;
      d1_q    <= '0;
      d0_q    <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.BUSY   = (state_q == CONV);
  assign bus.BCD    = bcd;
  assign bus.DIG_EN = dig_en;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - directed scoreboard bench for disp_scan_ctrl
module tb_disp_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] val = 8'd0;
  logic       load = 1'b0;

  always #5 clk = ~clk;

  disp_scan_ctrl_if bus_lz ();
  disp_scan_ctrl_if bus_nz ();

  assign bus_lz.VAL  = val;
  assign bus_lz.LOAD = load;
  assign bus_nz.VAL  = val;
  assign bus_nz.LOAD = load;

  disp_scan_ctrl #(.SCAN_DIV(4), .DIV_W(2), .LZB(1'b1)) dut_lz (
    .CLK(clk), .RST_N(rst_n), .bus(bus_lz.slave));
  disp_scan_ctrl #(.SCAN_DIV(4), .DIV_W(16), .LZB(1'b0)) dut_nz (
    .CLK(clk), .RST_N(rst_n), .bus(bus_nz.slave));

  typedef struct packed {
    logic [7:0] v;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [3:0] rd_bcd[3];
  logic [3:0] rd_bcd_lz[3];
  logic [2:0] rd_en_nz[3];
  logic [2:0] rd_en_lz[3];

  function automatic exp_t model(input int v);
    exp_t e;
    e.v  = 8'(v);
    e.d2 = 4'(v / 100);
    e.d1 = 4'((v / 10) % 10);
    e.d0 = 4'(v % 10);
    return e;
  endfunction

  function automatic logic [3:0] digit_for(input exp_t e, input logic [2:0] en);
    case (en)
      3'b001:  return e.d0;
      3'b010:  return e.d1;
      3'b100:  return e.d2;
      default: return 4'hF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic read_display();
    int guard;
    guard = 0;
    while (bus_nz.DIG_EN !== 3'b100 && guard < 40) begin @(negedge clk); guard++; end
    while (bus_nz.DIG_EN === 3'b100 && guard < 40) begin @(negedge clk); guard++; end
    check("scan_sync", 16'(bus_nz.DIG_EN), 16'(3'b001));
    for (int k = 0; k < 3; k++) begin
      rd_bcd[k]    = bus_nz.BCD;
      rd_bcd_lz[k] = bus_lz.BCD;
      rd_en_nz[k]  = bus_nz.DIG_EN;
      rd_en_lz[k]  = bus_lz.DIG_EN;
      if (k < 2) repeat (4) @(negedge clk);
    end
  endtask

  task automatic run_conv(input int v);
    int hi;
    val  = 8'(v);
    load = 1'b1;
    sb.push_back(model(v));
    @(negedge clk);
    load = 1'b0;
    hi = 0;
    while (bus_nz.BUSY === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
    check("busy_len", 16'(hi), 16'd8);
  endtask

  task automatic verify(input string tag);
    exp_t e;
    logic [2:0] en_t, en_h;
    check({tag, "_sb_nonempty"}, 16'(sb.size() > 0), 16'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      read_display();
      check({tag, "_ones"}, 16'(rd_bcd[0]), 16'(e.d0));
      check({tag, "_tens"}, 16'(rd_bcd[1]), 16'(e.d1));
      check({tag, "_hund"}, 16'(rd_bcd[2]), 16'(e.d2));
      check({tag, "_sum"}, 16'(rd_bcd[2]) * 16'd100 + 16'(rd_bcd[1]) * 16'd10 + 16'(rd_bcd[0]), 16'(e.v));
      check({tag, "_digits_le9"}, 16'(rd_bcd[0] <= 4'd9 && rd_bcd[1] <= 4'd9 && rd_bcd[2] <= 4'd9), 16'd1);
      en_t = (e.d2 == 4'd0 && e.d1 == 4'd0) ? 3'b000 : 3'b010;
      en_h = (e.d2 == 4'd0) ? 3'b000 : 3'b100;
      check({tag, "_en_nz"}, {7'd0, rd_en_nz[2], rd_en_nz[1], rd_en_nz[0]}, {7'd0, 3'b100, 3'b010, 3'b001});
      check({tag, "_en_lz"}, {7'd0, rd_en_lz[2], rd_en_lz[1], rd_en_lz[0]}, {7'd0, en_h, en_t, 3'b001});
      check({tag, "_bcd_lz"}, {4'd0, rd_bcd_lz[2], rd_bcd_lz[1], rd_bcd_lz[0]}, {4'd0, e.d2, e.d1, e.d0});
    end
  endtask

  initial begin
    exp_t e;
    int busy_seen;

    // Reset held for two edges, then the blank scan of value 0.
    repeat (2) @(negedge clk);
    check("rst_busy", 16'(bus_nz.BUSY), 16'd0);
    check("rst_bcd", 16'(bus_nz.BCD), 16'd0);
    check("rst_en_nz", 16'(bus_nz.DIG_EN), 16'(3'b001));
    check("rst_en_lz", 16'(bus_lz.DIG_EN), 16'(3'b001));
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("scan0_en_nz", 16'(bus_nz.DIG_EN), 16'(3'b001 << (i / 4)));
      check("scan0_en_lz", 16'(bus_lz.DIG_EN), (i / 4 == 0) ? 16'(3'b001) : 16'd0);
      check("scan0_bcd", 16'(bus_lz.BCD), 16'd0);
      @(negedge clk);
    end

    run_conv(255); verify("v255");
    run_conv(7);   verify("v7");
    run_conv(100); verify("v100");

    // Second LOAD at E3 becomes a pending request started at E9.
    val = 8'd12; load = 1'b1; sb.push_back(model(12));
    @(negedge clk);
    load = 1'b0;
    check("pend_busy_e0", 16'(bus_nz.BUSY), 16'd1);
    @(negedge clk);
    @(negedge clk);
    val = 8'd200; load = 1'b1; sb.push_back(model(200));
    @(negedge clk);
    load = 1'b0;
    repeat (4) begin @(negedge clk); check("pend_busy_mid", 16'(bus_nz.BUSY), 16'd1); end
    @(negedge clk);
    check("pend_busy_gap", 16'(bus_nz.BUSY), 16'd0);
    e = sb.pop_front();
    for (int i = 0; i < 9; i++) begin
      check("pend_first_digit", 16'(bus_nz.BCD), 16'(digit_for(e, bus_nz.DIG_EN)));
      if (i == 1) check("pend_busy_e9", 16'(bus_nz.BUSY), 16'd1);
      @(negedge clk);
    end
    check("pend_busy_e17", 16'(bus_nz.BUSY), 16'd0);
    verify("pend200");
    check("pend_idle_after", 16'(bus_nz.BUSY), 16'd0);

    // Reset at E4 aborts the conversion and drops the pending request.
    run_conv(42); verify("v42");
    val = 8'd99; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 16'(bus_nz.BUSY), 16'd0);
    check("abort_bcd", 16'(bus_nz.BCD), 16'd0);
    check("abort_en_nz", 16'(bus_nz.DIG_EN), 16'(3'b001));
    check("abort_en_lz", 16'(bus_lz.DIG_EN), 16'(3'b001));
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (20) begin @(negedge clk); if (bus_nz.BUSY !== 1'b0) busy_seen++; end
    check("abort_no_restart", 16'(busy_seen), 16'd0);
    sb.push_back(model(0));
    verify("abort");

    for (int v = 0; v < 256; v++) begin
      run_conv(v);
      verify("sweep");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end
endmodule
